// File: rtl/packet_framer_pkg.sv
// Shared types and reset constants for the Avalon-ST packet framer.
package packet_framer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_SEND_SOP  = 5'b00010,
    ST_ACCEPT    = 5'b00100,
    ST_SEND_DATA = 5'b01000,
    ST_SEND_EOP  = 5'b10000
  } state_e;

  localparam state_e      STATE_RST      = ST_IDLE;
  localparam int unsigned PKT_CNT_W      = 16;
  localparam logic [15:0] PKT_CNT_RST    = 16'd0;

endpackage

// File: rtl/packet_framer_avalon_st.sv
// Frames an undelimited stream into SOP / LENGTH data beats / EOP packets,
// with early close via flush and a software-visible length register.
module packet_framer_avalon_st
  import packet_framer_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned DEFAULT_LENGTH = 4,
  parameter int unsigned SOP_VALUE      = 0,
  parameter int unsigned EOP_VALUE      = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 flush,
  input  logic                 length_write,
  input  logic [LEN_WIDTH-1:0] length_writedata,
  input  logic                 length_read,
  output logic [LEN_WIDTH-1:0] length_readdata,
  output logic                 in_packet,
  output logic [15:0]          packet_count
);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic                   capture_s;
  logic [LEN_WIDTH-1:0]   length_r;
  logic [LEN_WIDTH-1:0]   snap_r;
  logic [LEN_WIDTH-1:0]   cnt_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   sop_r;
  logic                   eop_r;
  logic [WIDTH-1:0]       out_data_r;
  logic                   in_packet_r;
  logic [PKT_CNT_W-1:0]   pkt_cnt_r;

  assign in_ready          = in_ready_r;
  assign out_valid         = out_valid_r;
  assign out_startofpacket = sop_r;
  assign out_endofpacket   = eop_r;
  assign out_data          = out_data_r;
  assign in_packet         = in_packet_r;
  assign packet_count      = pkt_cnt_r;
  assign length_readdata   = length_read ? length_r : {LEN_WIDTH{1'b0}};

  // Next-state decode; any non-one-hot encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_SEND_SOP;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SEND_SOP: begin
        if (out_ready) state_nxt_s = ST_ACCEPT;
        else           state_nxt_s = ST_SEND_SOP;
      end
      ST_ACCEPT: begin
        if (flush) begin
          state_nxt_s = ST_SEND_EOP;
        end else if (in_valid) begin
          state_nxt_s = ST_SEND_DATA;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_ACCEPT;
        end
      end
      ST_SEND_DATA: begin
        if (out_ready) state_nxt_s = (cnt_r == snap_r) ? ST_SEND_EOP : ST_ACCEPT;
        else           state_nxt_s = ST_SEND_DATA;
      end
      ST_SEND_EOP: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_SEND_EOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters, length register and outputs registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= STATE_RST;
      length_r    <= LEN_WIDTH'(DEFAULT_LENGTH);
      snap_r      <= LEN_WIDTH'(DEFAULT_LENGTH);
      cnt_r       <= {LEN_WIDTH{1'b0}};
      pkt_cnt_r   <= PKT_CNT_RST;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      in_packet_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && in_valid) begin
        snap_r <= length_r;
        cnt_r  <= {LEN_WIDTH{1'b0}};
      end else if (capture_s) begin
        cnt_r  <= cnt_r + LEN_WIDTH'(1'b1);
      end
      if (length_write && (length_writedata != {LEN_WIDTH{1'b0}})) begin
        length_r <= length_writedata;
      end
      if (state_r == ST_SEND_EOP && out_ready) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      in_packet_r <= 1'b1;
      case (state_nxt_s)
        ST_SEND_SOP: begin
          out_valid_r <= 1'b1;
          sop_r       <= 1'b1;
          out_data_r  <= WIDTH'(SOP_VALUE);
        end
        ST_ACCEPT: begin
          in_ready_r <= 1'b1;
        end
        // Hold the captured word across back-pressure.
        ST_SEND_DATA: begin
          out_valid_r <= 1'b1;
          out_data_r  <= capture_s ? in_data : out_data_r;
        end
        ST_SEND_EOP: begin
          out_valid_r <= 1'b1;
          eop_r       <= 1'b1;
          out_data_r  <= WIDTH'(EOP_VALUE);
        end
        default: begin
          in_packet_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
